// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port, fixed-latency unified memory.
// The data port has priority; the fetch port wins once it has been passed over STARVE_MAX times.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_ack,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_rd,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [3:0] MEM_LAT_C    = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    state_t            stateReg, stateNext;
    logic              ownerInstReg;
    logic [3:0]        latCntReg;
    logic [3:0]        starveCntReg;
    logic [DATA_W-1:0] instRdataReg;
    logic [DATA_W-1:0] dataRdataReg;

    logic dataReq;
    logic instWins;
    logic issue;
    logic issueWrite;

    assign dataReq    = data_rd | data_wr;
    assign instWins   = inst_req & (~dataReq | (starveCntReg == STARVE_MAX_C));
    // Issue is gated by reset so nothing leaves the arbiter while it is being cleared.
    assign issue      = (stateReg == IDLE) & (inst_req | dataReq) & ~reset;
    // rd+wr together is a write; the fetch port can never write.
    assign issueWrite = ~instWins & data_wr;

    always_comb begin
        stateNext = stateReg;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (stateReg)
            IDLE: begin
                if (issue) begin
                    mem_en    = 1'b1;
                    mem_we    = issueWrite;
                    mem_addr  = instWins ? inst_addr : data_addr;
                    mem_wdata = issueWrite ? data_wdata : '0;
                    stateNext = issueWrite ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (latCntReg == MEM_LAT_C) begin
                    stateNext = ACK;
                end
            end
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign inst_ack   = (stateReg == ACK) &  ownerInstReg;
    assign data_ack   = (stateReg == ACK) & ~ownerInstReg;
    assign inst_rdata = instRdataReg;
    assign data_rdata = dataRdataReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= IDLE;
            ownerInstReg <= 1'b0;
            latCntReg    <= '0;
            starveCntReg <= '0;
            instRdataReg <= '0;
            dataRdataReg <= '0;
        end else begin
            stateReg <= stateNext;

            if (issue) begin
                ownerInstReg <= instWins;
                latCntReg    <= 4'd1;
            end

            // The word arrives MEM_LAT cycles after issue; the counter was preset to 1 at issue.
            if (stateReg == WAIT) begin
                if (latCntReg == MEM_LAT_C) begin
                    latCntReg <= '0;
                    if (ownerInstReg) begin
                        instRdataReg <= mem_rdata;
                    end else begin
                        dataRdataReg <= mem_rdata;
                    end
                end else begin
                    latCntReg <= latCntReg + 4'd1;
                end
            end

            if (stateReg == IDLE) begin
                if (!inst_req || (issue && instWins)) begin
                    starveCntReg <= '0;
                end else if (issue && (starveCntReg < STARVE_MAX_C)) begin
                    starveCntReg <= starveCntReg + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed stimulus pushes expected issues/acks into queues,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        data_rd = 1'b0;
    logic        data_wr = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_ack   (inst_ack),
        .inst_rdata (inst_rdata),
        .data_rd    (data_rd),
        .data_wr    (data_wr),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_ack   (data_ack),
        .data_rdata (data_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Memory model: writes on the issue edge, read data valid two cycles after issue.
    logic [31:0] memArr [256];
    logic [31:0] stage1 = '0;
    logic [31:0] stage2 = '0;
    assign mem_rdata = stage2;

    always @(posedge clk) begin
        if (cyc == 0) begin
            memArr[8'h10] <= 32'hDEADBEEF;
            memArr[8'h40] <= 32'hA1A1A1A1;
            memArr[8'h44] <= 32'hB2B2B2B2;
            memArr[8'h50] <= 32'hCAFEF00D;
        end else if (mem_en && mem_we) begin
            memArr[mem_addr[7:0]] <= mem_wdata;
        end
        stage1 <= (mem_en && !mem_we) ? memArr[mem_addr[7:0]] : 32'hBAD0BAD0;
        stage2 <= stage1;
    end

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } issue_t;

    typedef struct {
        int          cyc;
        logic        isInst;
        logic [31:0] rdata;
    } ack_t;

    issue_t issQ[$];
    ack_t   ackQ[$];

    task automatic expIssue(input int c, input logic we, input logic [31:0] a, input logic [31:0] wd);
        issue_t e;
        e.cyc = c; e.we = we; e.addr = a; e.wdata = wd;
        issQ.push_back(e);
    endtask

    task automatic expAck(input int c, input logic isInst, input logic [31:0] rd);
        ack_t e;
        e.cyc = c; e.isInst = isInst; e.rdata = rd;
        ackQ.push_back(e);
    endtask

    // Monitor
    logic prevEn = 1'b0;
    always @(negedge clk) begin
        issue_t ei;
        ack_t   ea;
        check("no_back_to_back_issue", 32'(prevEn & mem_en), 32'd0);
        check("single_ack", 32'(inst_ack & data_ack), 32'd0);
        if (!mem_en) check("idle_mem_addr", mem_addr, 32'd0);
        if (!mem_we) check("idle_mem_wdata", mem_wdata, 32'd0);
        if (mem_en) begin
            if (issQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpected_issue at cycle %0d: got addr 0x%08h, expected no issue", cyc, mem_addr);
            end else begin
                ei = issQ.pop_front();
                check("issue_cycle", 32'(cyc), 32'(ei.cyc));
                check("issue_we", 32'(mem_we), 32'(ei.we));
                check("issue_addr", mem_addr, ei.addr);
                check("issue_wdata", mem_wdata, ei.wdata);
            end
        end
        if (inst_ack || data_ack) begin
            if (ackQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpected_ack at cycle %0d: got inst_ack=%0b data_ack=%0b, expected none",
                         cyc, inst_ack, data_ack);
            end else begin
                ea = ackQ.pop_front();
                check("ack_cycle", 32'(cyc), 32'(ea.cyc));
                check("ack_port_is_inst", 32'(inst_ack), 32'(ea.isInst));
                check("ack_rdata", inst_ack ? inst_rdata : data_rdata, ea.rdata);
                $display("cycle %0d: %s ack, rdata=0x%08h", cyc, inst_ack ? "inst" : "data",
                         inst_ack ? inst_rdata : data_rdata);
            end
        end
        prevEn <= mem_en;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish by 20000 time units");
        $fatal(1, "watchdog");
    end

    task automatic gotoCycle(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        gotoCycle(3);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_inst_ack", 32'(inst_ack), 32'd0);
        check("rst_data_ack", 32'(data_ack), 32'd0);
        check("rst_inst_rdata", inst_rdata, 32'd0);
        check("rst_data_rdata", data_rdata, 32'd0);
        gotoCycle(4);
        reset = 1'b0;

        // Fetch only, request held through a second issue
        gotoCycle(10);
        inst_addr = 32'h10;
        inst_req  = 1'b1;
        expIssue(10, 1'b0, 32'h10, 32'h0);
        expAck(13, 1'b1, 32'hDEADBEEF);
        expIssue(14, 1'b0, 32'h10, 32'h0);
        expAck(17, 1'b1, 32'hDEADBEEF);
        gotoCycle(17);
        inst_req = 1'b0;
        gotoCycle(20);
        check("inst_rdata_hold", inst_rdata, 32'hDEADBEEF);

        // Write then read back
        gotoCycle(22);
        data_addr  = 32'h20;
        data_wdata = 32'h12345678;
        data_wr    = 1'b1;
        expIssue(22, 1'b1, 32'h20, 32'h12345678);
        expAck(23, 1'b0, 32'h0);
        expIssue(24, 1'b0, 32'h20, 32'h0);
        expAck(27, 1'b0, 32'h12345678);
        gotoCycle(23);
        data_wr = 1'b0;
        data_rd = 1'b1;
        gotoCycle(27);
        data_rd = 1'b0;
        gotoCycle(28);
        check("data_rdata_hold", data_rdata, 32'h12345678);

        // Simultaneous rd+wr is a single write
        gotoCycle(30);
        data_addr  = 32'h30;
        data_wdata = 32'h5;
        data_rd    = 1'b1;
        data_wr    = 1'b1;
        expIssue(30, 1'b1, 32'h30, 32'h5);
        expAck(31, 1'b0, 32'h12345678);
        gotoCycle(31);
        data_rd = 1'b0;
        data_wr = 1'b0;
        gotoCycle(33);
        check("rdwr_data_rdata_unchanged", data_rdata, 32'h12345678);

        // Contention: D,D,D,D,I,D,D,D,D,I
        gotoCycle(40);
        data_addr = 32'h40;
        inst_addr = 32'h44;
        data_rd   = 1'b1;
        inst_req  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                expIssue(40 + 4 * i, 1'b0, 32'h44, 32'h0);
                expAck(43 + 4 * i, 1'b1, 32'hB2B2B2B2);
            end else begin
                expIssue(40 + 4 * i, 1'b0, 32'h40, 32'h0);
                expAck(43 + 4 * i, 1'b0, 32'hA1A1A1A1);
            end
        end
        gotoCycle(79);
        data_rd  = 1'b0;
        inst_req = 1'b0;

        // Reset in the middle of a data read
        gotoCycle(90);
        data_addr = 32'h50;
        data_rd   = 1'b1;
        expIssue(90, 1'b0, 32'h50, 32'h0);
        gotoCycle(91);
        reset   = 1'b1;
        data_rd = 1'b0;
        gotoCycle(92);
        check("midrst_data_ack", 32'(data_ack), 32'd0);
        check("midrst_mem_en", 32'(mem_en), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_data_rdata", data_rdata, 32'd0);
        check("midrst_inst_rdata", inst_rdata, 32'd0);
        reset = 1'b0;
        gotoCycle(94);
        check("midrst_late_rdata_ignored", data_rdata, 32'd0);
        gotoCycle(95);
        data_rd = 1'b1;
        expIssue(95, 1'b0, 32'h50, 32'h0);
        expAck(98, 1'b0, 32'hCAFEF00D);
        gotoCycle(98);
        data_rd = 1'b0;

        // Idle stretch
        gotoCycle(110);
        check("idle_mem_en", 32'(mem_en), 32'd0);
        check("idle_addr_mid", mem_addr, 32'd0);
        gotoCycle(125);
        check("issue_queue_drained", 32'(issQ.size()), 32'd0);
        check("ack_queue_drained", 32'(ackQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
